lpc_decode: RTL and testbench

LPC synthesis (decode) block, the receive-side counterpart of the LPC encoder. It accepts a 160-sample frame of 16-bit residue and 10 LPC coefficients, then runs the all-pole synthesis filter x[n] = e[n] − Σ a[k]·x[n−k] for k = 1..10 with one sequential multiply-accumulate per cycle. The reconstructed frame is stored for random-access readout. It sits after residue/coefficient transport and before the audio output path.

---
 rtl/lpc_decode_pkg.sv | 37 +++
 rtl/lpc_synth_mac.sv | 59 +++++
 rtl/lpc_decode.sv | 154 +++++++++++++++
 tb/tb_lpc_decode.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpc_decode_pkg.sv
// ============================================================================
// Module   : lpc_decode_pkg
// Purpose  : Shared constants, FSM state type and saturation helper for the
//            LPC synthesis (decode) block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lpc_decode_pkg;

    localparam int FRAME_LEN = 160;
    localparam int ORDER     = 10;
    localparam int COEF_FRAC = 28;
    localparam int ACC_W     = 52;
    localparam int PROD_W    = 48;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_MAC   = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic signed [15:0] sat16(input logic signed [24:0] v);
        if (v > 25'sd32767) begin
            return 16'sh7fff;
        end else if (v < -25'sd32768) begin
            return 16'sh8000;
        end else begin
            return v[15:0];
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/lpc_synth_mac.sv
// ============================================================================
// Module   : lpc_synth_mac
// Purpose  : 16x32 signed multiply-accumulate with round/shift/saturate that
//            forms y = sat16(e - round(acc >> 28)).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lpc_synth_mac
    import lpc_decode_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        acc_en,
    input  logic [31:0] coef,
    input  logic [15:0] samp,
    input  logic [15:0] e,
    output logic [15:0] y
);

    localparam logic signed [ACC_W-1:0] RND = ACC_W'(64'd1 << (COEF_FRAC - 1));

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_rnd;
    logic signed [23:0]       acc_shr;
    logic signed [24:0]       diff;

    assign prod = $signed({{(PROD_W-16){samp[15]}}, samp})
                * $signed({{(PROD_W-32){coef[31]}}, coef});

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (acc_en) begin
            acc_d = acc_q + $signed({{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod});
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Round half up, then arithmetic shift down to 24 bits before the subtract
    assign acc_rnd = acc_q + RND;
    assign acc_shr = acc_rnd[ACC_W-1:COEF_FRAC];
    assign diff    = $signed({{9{e[15]}}, e}) - $signed({acc_shr[23], acc_shr});
    assign y       = sat16(diff);

endmodule

`default_nettype wire

// File: rtl/lpc_decode.sv
// ============================================================================
// Module   : lpc_decode
// Purpose  : LPC all-pole synthesis filter over a 160-sample frame, order 10,
//            one MAC per cycle, with random-access readout of the result.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lpc_decode
    import lpc_decode_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        ready,
    input  logic        a_wen,
    input  logic [3:0]  a_waddr,
    input  logic [31:0] a_din,
    input  logic        residue_wen,
    input  logic [7:0]  residue_waddr,
    input  logic [15:0] residue_din,
    input  logic [7:0]  x_raddr,
    output logic [15:0] x_dout
);

    localparam logic [7:0] LAST_N = 8'(FRAME_LEN - 1);
    localparam logic [3:0] LAST_K = 4'(ORDER - 1);

    state_t      state_d, state_q;
    logic [7:0]  n_d, n_q;
    logic [3:0]  k_d, k_q;
    logic [15:0] e_d, e_q;
    logic        ready_d, ready_q;
    logic [31:0] coef_d  [ORDER];
    logic [31:0] coef_q  [ORDER];
    logic [15:0] hist_d  [ORDER];
    logic [15:0] hist_q  [ORDER];
    logic [15:0] resid_d [FRAME_LEN];
    logic [15:0] resid_q [FRAME_LEN];
    logic [15:0] x_d     [FRAME_LEN];
    logic [15:0] x_q     [FRAME_LEN];

    logic        mac_clr;
    logic        mac_en;
    logic [15:0] mac_y;

    lpc_synth_mac u_mac (
        .clk    (clk),
        .reset  (reset),
        .clr    (mac_clr),
        .acc_en (mac_en),
        .coef   (coef_q[k_q]),
        .samp   (hist_q[k_q]),
        .e      (e_q),
        .y      (mac_y)
    );

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        k_d     = k_q;
        e_d     = e_q;
        ready_d = ready_q;
        coef_d  = coef_q;
        hist_d  = hist_q;
        resid_d = resid_q;
        x_d     = x_q;
        mac_clr = 1'b0;
        mac_en  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (a_wen && (a_waddr < 4'(ORDER))) begin
                    coef_d[a_waddr] = a_din;
                end
                if (residue_wen && (residue_waddr < 8'(FRAME_LEN))) begin
                    resid_d[residue_waddr] = residue_din;
                end
                if (start) begin
                    state_d = ST_INIT;
                    n_d     = '0;
                    ready_d = 1'b0;
                    for (int i = 0; i < ORDER; i++) begin
                        hist_d[i] = '0;
                    end
                end
            end
            ST_INIT: begin
                e_d     = resid_q[n_q];
                k_d     = '0;
                mac_clr = 1'b1;
                state_d = ST_MAC;
            end
            ST_MAC: begin
                mac_en = 1'b1;
                k_d    = k_q + 4'd1;
                if (k_q == LAST_K) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                x_d[n_q]  = mac_y;
                hist_d[0] = mac_y;
                for (int i = 1; i < ORDER; i++) begin
                    hist_d[i] = hist_q[i-1];
                end
                if (n_q == LAST_N) begin
                    state_d = ST_DONE;
                    ready_d = 1'b1;
                end else begin
                    n_d     = n_q + 8'd1;
                    state_d = ST_INIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            k_q     <= '0;
            e_q     <= '0;
            ready_q <= 1'b0;
            for (int i = 0; i < ORDER; i++) begin
                coef_q[i] <= '0;
                hist_q[i] <= '0;
            end
            for (int i = 0; i < FRAME_LEN; i++) begin
                resid_q[i] <= '0;
                x_q[i]     <= '0;
            end
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
            e_q     <= e_d;
            ready_q <= ready_d;
            coef_q  <= coef_d;
            hist_q  <= hist_d;
            resid_q <= resid_d;
            x_q     <= x_d;
        end
    end

    assign ready  = ready_q;
    assign x_dout = (x_raddr < 8'(FRAME_LEN)) ? x_q[x_raddr] : 16'd0;

endmodule

`default_nettype wire

// File: tb/tb_lpc_decode.sv
// ============================================================================
// Module   : tb_lpc_decode
// Purpose  : Directed self-checking bench for the LPC synthesis block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lpc_decode;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        ready;
    logic        a_wen = 1'b0;
    logic [3:0]  a_waddr = '0;
    logic [31:0] a_din = '0;
    logic        residue_wen = 1'b0;
    logic [7:0]  residue_waddr = '0;
    logic [15:0] residue_din = '0;
    logic [7:0]  x_raddr = '0;
    logic [15:0] x_dout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lpc_decode dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .ready         (ready),
        .a_wen         (a_wen),
        .a_waddr       (a_waddr),
        .a_din         (a_din),
        .residue_wen   (residue_wen),
        .residue_waddr (residue_waddr),
        .residue_din   (residue_din),
        .x_raddr       (x_raddr),
        .x_dout        (x_dout)
    );

    task automatic write_coef(input int idx, input logic [31:0] v);
        a_wen = 1'b1; a_waddr = 4'(idx); a_din = v;
        @(posedge clk); #1;
        a_wen = 1'b0;
    endtask

    task automatic write_res(input int idx, input logic [15:0] v);
        residue_wen = 1'b1; residue_waddr = 8'(idx); residue_din = v;
        @(posedge clk); #1;
        residue_wen = 1'b0;
    endtask

    // Pulses start; returns edges from E0 until ready is seen (-1 on timeout)
    task automatic run_frame(input bit disturb, output int cycles);
        cycles = -1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; residue_wen = 1'b0; a_wen = 1'b0;
        for (int c = 1; c <= 2200; c++) begin
            if (disturb && c == 500) start = 1'b1;
            if (disturb && c == 501) start = 1'b0;
            if (disturb && c == 600) begin
                residue_wen = 1'b1; residue_waddr = 8'd159; residue_din = 16'd999;
                a_wen = 1'b1; a_waddr = 4'd0; a_din = 32'h1000_0000;
            end
            if (disturb && c == 601) begin
                residue_wen = 1'b0; a_wen = 1'b0;
            end
            @(posedge clk); #1;
            if (ready) begin
                cycles = c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 0", ready);
        end
        for (int a = 0; a < 256; a += 85) begin
            x_raddr = 8'(a); #1;
            n_checks++;
            if (x_dout !== 16'd0) begin
                n_fail++; $display("FAIL reset_x[%0d]: got %0d expected 0", a, x_dout);
            end
        end
    endtask

    task automatic test_passthrough;
        int cyc;
        for (int i = 0; i < 160; i++) write_res(i, 16'(i - 80));
        run_frame(1'b0, cyc);
        n_checks++;
        if (cyc !== 1920) begin
            n_fail++; $display("FAIL pass_latency: got %0d expected 1920", cyc);
        end
        for (int i = 0; i < 160; i++) begin
            x_raddr = 8'(i); #1;
            n_checks++;
            if ($signed(x_dout) !== 16'(i - 80)) begin
                n_fail++; $display("FAIL pass_x[%0d]: got %0d expected %0d", i, $signed(x_dout), i - 80);
            end
        end
        x_raddr = 8'd200; #1;
        n_checks++;
        if (x_dout !== 16'd0) begin
            n_fail++; $display("FAIL pass_oob: got %0d expected 0", x_dout);
        end
    endtask

    task automatic test_busy_ignore;
        int cyc;
        run_frame(1'b1, cyc);
        n_checks++;
        if (cyc !== 1920) begin
            n_fail++; $display("FAIL busy_latency: got %0d expected 1920", cyc);
        end
        for (int i = 0; i < 160; i++) begin
            x_raddr = 8'(i); #1;
            n_checks++;
            if ($signed(x_dout) !== 16'(i - 80)) begin
                n_fail++; $display("FAIL busy_x[%0d]: got %0d expected %0d", i, $signed(x_dout), i - 80);
            end
        end
    endtask

    task automatic test_same_cycle_write;
        int cyc;
        residue_wen = 1'b1; residue_waddr = 8'd0; residue_din = 16'd1234;
        run_frame(1'b0, cyc);
        x_raddr = 8'd0; #1;
        n_checks++;
        if (x_dout !== 16'd1234) begin
            n_fail++; $display("FAIL same_cycle_x0: got %0d expected 1234", $signed(x_dout));
        end
        x_raddr = 8'd1; #1;
        n_checks++;
        if ($signed(x_dout) !== -16'sd79) begin
            n_fail++; $display("FAIL same_cycle_x1: got %0d expected -79", $signed(x_dout));
        end
    endtask

    task automatic load_rounding;
        for (int i = 0; i < 160; i++) write_res(i, (i == 0) ? 16'd16384 : 16'd0);
        write_coef(0, 32'hF800_0000);
        for (int k = 1; k < 10; k++) write_coef(k, 32'd0);
    endtask

    task automatic check_rounding(input string tag);
        logic [15:0] exp;
        for (int i = 0; i < 160; i++) begin
            exp = (i <= 14) ? 16'(16384 >> i) : 16'd0;
            x_raddr = 8'(i); #1;
            n_checks++;
            if (x_dout !== exp) begin
                n_fail++; $display("FAIL %s_x[%0d]: got %0d expected %0d", tag, i, $signed(x_dout), exp);
            end
        end
    endtask

    task automatic test_rounding;
        int cyc;
        load_rounding();
        run_frame(1'b0, cyc);
        n_checks++;
        if (cyc !== 1920) begin
            n_fail++; $display("FAIL round_latency: got %0d expected 1920", cyc);
        end
        check_rounding("round");
    endtask

    task automatic test_saturate;
        int cyc;
        logic [15:0] exp;
        write_coef(0, 32'hF000_0000);
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 160; i++) write_res(i, (s == 0) ? 16'd20000 : 16'hB1E0);
            run_frame(1'b0, cyc);
            for (int i = 0; i < 160; i++) begin
                if (i == 0) exp = (s == 0) ? 16'd20000 : 16'hB1E0;
                else        exp = (s == 0) ? 16'h7FFF  : 16'h8000;
                x_raddr = 8'(i); #1;
                n_checks++;
                if (x_dout !== exp) begin
                    n_fail++; $display("FAIL sat%0d_x[%0d]: got %0d expected %0d", s, i, $signed(x_dout), $signed(exp));
                end
            end
        end
    endtask

    task automatic test_loopback;
        int cyc;
        int xo [160];
        longint coef [10];
        longint acc;
        int diff;
        for (int k = 0; k < 10; k++) begin
            coef[k] = ((k % 2) ? 64'sd1 : -64'sd1) * longint'(k + 1) * 64'sd1500000;
            write_coef(k, 32'(coef[k]));
        end
        for (int n = 0; n < 160; n++) begin
            xo[n] = (((n * 37) % 200) - 100) * 40;
            acc = 0;
            for (int k = 0; k < 10; k++) begin
                if (n - 1 - k >= 0) acc += coef[k] * longint'(xo[n-1-k]);
            end
            write_res(n, 16'(longint'(xo[n]) + ((acc + 64'sd134217728) >>> 28)));
        end
        run_frame(1'b0, cyc);
        for (int n = 0; n < 160; n++) begin
            x_raddr = 8'(n); #1;
            diff = int'($signed(x_dout)) - xo[n];
            n_checks++;
            if (diff > 2 || diff < -2) begin
                n_fail++; $display("FAIL loop_x[%0d]: got %0d expected %0d", n, $signed(x_dout), xo[n]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int cyc;
        int bad;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (1000) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++; $display("FAIL midrst_ready: got %b expected 0", ready);
        end
        bad = -1;
        for (int a = 0; a < 256; a++) begin
            x_raddr = 8'(a); #1;
            if (x_dout !== 16'd0 && bad < 0) bad = a;
        end
        n_checks++;
        if (bad >= 0) begin
            n_fail++; $display("FAIL midrst_x: nonzero at addr %0d expected all 0", bad);
        end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        write_res(0, 16'd16384);
        write_coef(0, 32'hF800_0000);
        run_frame(1'b0, cyc);
        n_checks++;
        if (cyc !== 1920) begin
            n_fail++; $display("FAIL midrst_latency: got %0d expected 1920", cyc);
        end
        check_rounding("midrst");
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_passthrough();
        test_busy_ignore();
        test_same_cycle_write();
        test_rounding();
        test_saturate();
        test_loopback();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
